// File: rtl/qea_loader_pkg.sv
// Shared constants, FSM encoding and helpers for the QEA host loader.
package qea_loader_pkg;

  localparam int PE_NUM_WIDTH            = 2;
  localparam int PE_NUM                  = 4;
  localparam int DATA_WIDTH              = 32;
  localparam int STATE_DATA_WIDTH        = 64;
  localparam int STATE_ADDR_WIDTH        = 16;
  localparam int GATE_CONTEXT_DATA_WIDTH = 64;
  localparam int GATE_CONTEXT_ADDR_WIDTH = 16;
  localparam int MAX_QBIT_WIDTH          = 6;
  localparam int NUM_FRAC_BIT            = 30;

  localparam int STATE_WORD_WIDTH = PE_NUM * STATE_DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] ONE_FIXED = DATA_WIDTH'(1) << NUM_FRAC_BIT;

  // |0..0> lives in the top PE slice: real part 1.0, imaginary part 0.
  localparam logic [STATE_WORD_WIDTH-1:0] BASIS_WORD =
    {ONE_FIXED, {(STATE_WORD_WIDTH - DATA_WIDTH){1'b0}}};

  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_CTX   = 3'd1,
    ST_INIT_STATE = 3'd2,
    ST_START      = 3'd3,
    ST_RUN        = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // One extra bit so a full 2^STATE_ADDR_WIDTH word count is representable.
  typedef logic [STATE_ADDR_WIDTH:0] word_cnt_t;

  function automatic logic qbit_legal(input logic [MAX_QBIT_WIDTH-1:0] qbit_num);
    return (qbit_num >= QBIT_MIN) && (qbit_num <= QBIT_MAX);
  endfunction

  function automatic word_cnt_t state_words(input logic [MAX_QBIT_WIDTH-1:0] qbit_num);
    return word_cnt_t'(1) << (qbit_num - QBIT_MIN);
  endfunction

endpackage

// File: rtl/qea_state_init_gen.sv
// Writes the |0..0> basis state: word 0 = BASIS_WORD, words 1..N-1 = 0, one per cycle.
module qea_state_init_gen
  import qea_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  word_cnt_t                   word_cnt_i,
  output logic                        ena_o,
  output logic                        wea_o,
  output logic [STATE_ADDR_WIDTH-1:0] addr_o,
  output logic [STATE_WORD_WIDTH-1:0] data_o,
  output logic                        busy_o,
  output logic                        last_o
);

  word_cnt_t                   cnt_q;
  logic                        active_q;
  logic                        ena_q;
  logic                        last_q;
  logic [STATE_ADDR_WIDTH-1:0] addr_q;
  logic [STATE_WORD_WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      ena_q    <= 1'b0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      ena_q  <= 1'b0;
      last_q <= 1'b0;
      if (start_i && !active_q) begin
        cnt_q    <= '0;
        active_q <= 1'b1;
      end else if (active_q) begin
        ena_q  <= 1'b1;
        addr_q <= cnt_q[STATE_ADDR_WIDTH-1:0];
        data_q <= (cnt_q == '0) ? BASIS_WORD : '0;
        cnt_q  <= cnt_q + word_cnt_t'(1);
        // last_q rises together with the final write so the caller can advance.
        if (cnt_q == word_cnt_i - word_cnt_t'(1)) begin
          active_q <= 1'b0;
          last_q   <= 1'b1;
        end
      end
    end
  end

  assign ena_o  = ena_q;
  assign wea_o  = ena_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign busy_o = active_q;
  assign last_o = last_q;

endmodule

// File: rtl/qea_host_loader.sv
// Host-side sequencer for the QEA core: load context, init state, start, wait, done.
// Optional run-cycle counter output enabled by `define QEA_HOST_LOADER_CYCLE_CNT_EN.
module qea_host_loader
  import qea_loader_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_cmd_valid,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  input  logic                               s_ctx_valid,
  output logic                               s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_ctx_data,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [STATE_WORD_WIDTH-1:0]        o_state_dina,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  output logic                               o_qea_start,
  input  logic                               i_qea_complete,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
`ifdef QEA_HOST_LOADER_CYCLE_CNT_EN
  ,
  output logic [31:0]                        o_run_cycles
`endif
);

  state_e                               state_q;
  logic [MAX_QBIT_WIDTH-1:0]            qbit_num_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_num_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   beat_cnt_q;
  word_cnt_t                            word_cnt_q;
  logic                                 ctx_ready_q;
  logic                                 ctx_en_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q;
  logic                                 gen_start_q;
  logic                                 qea_start_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic                                 err_q;

  logic ctx_hs_d;
  logic gen_busy;
  logic gen_last;

  assign ctx_hs_d = ctx_ready_q && s_ctx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      qbit_num_q  <= '0;
      ins_num_q   <= '0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      ctx_ready_q <= 1'b0;
      ctx_en_q    <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      gen_start_q <= 1'b0;
      qea_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: strobes default low here so any branch that raises one yields
      // exactly a single-cycle pulse.
      ctx_en_q    <= 1'b0;
      gen_start_q <= 1'b0;
      qea_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            qbit_num_q <= i_qbit_num;
            ins_num_q  <= i_ins_num;
            beat_cnt_q <= '0;
            if (!qbit_legal(i_qbit_num)) begin
              err_q <= 1'b1;
            end else begin
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              word_cnt_q <= state_words(i_qbit_num);
              if (i_ins_num == '0) begin
                state_q     <= ST_INIT_STATE;
                gen_start_q <= 1'b1;
              end else begin
                state_q     <= ST_LOAD_CTX;
                ctx_ready_q <= 1'b1;
              end
            end
          end
        end
        ST_LOAD_CTX: begin
          if (ctx_hs_d) begin
            ctx_en_q   <= 1'b1;
            ctx_addr_q <= beat_cnt_q;
            ctx_data_q <= s_ctx_data;
            beat_cnt_q <= beat_cnt_q + GATE_CONTEXT_ADDR_WIDTH'(1);
            if (beat_cnt_q == ins_num_q - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
              ctx_ready_q <= 1'b0;
              state_q     <= ST_INIT_STATE;
              gen_start_q <= 1'b1;
            end
          end
        end
        ST_INIT_STATE: begin
          if (gen_last && !gen_busy) begin
            state_q     <= ST_START;
            qea_start_q <= 1'b1;
          end
        end
        ST_START: state_q <= ST_RUN;
        ST_RUN: begin
          if (i_qea_complete) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  qea_state_init_gen u_state_init_gen (
    .clk        (clk),
    .rst        (rst),
    .start_i    (gen_start_q),
    .word_cnt_i (word_cnt_q),
    .ena_o      (o_state_ena),
    .wea_o      (o_state_wea),
    .addr_o     (o_state_addra),
    .data_o     (o_state_dina),
    .busy_o     (gen_busy),
    .last_o     (gen_last)
  );

`ifdef QEA_HOST_LOADER_CYCLE_CNT_EN
  logic [31:0] run_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles_q <= '0;
    end else if (state_q == ST_START) begin
      run_cycles_q <= '0;
    end else if ((state_q == ST_RUN) && !(&run_cycles_q)) begin
      run_cycles_q <= run_cycles_q + 32'd1;
    end
  end

  assign o_run_cycles = run_cycles_q;
`endif

  assign s_ctx_ready = ctx_ready_q;
  assign o_ctx_en    = ctx_en_q;
  assign o_ctx_wea   = ctx_en_q;
  assign o_ctx_addr  = ctx_addr_q;
  assign o_ctx_data  = ctx_data_q;
  assign o_qbit_num  = qbit_num_q;
  assign o_qea_start = qea_start_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_qea_host_loader.sv
// Self-checking bench for qea_host_loader: command table plus RAM-write scoreboard.
module tb_qea_host_loader;

  localparam logic [255:0] BASIS = {64'h40000000_00000000, 192'h0};

  logic         clk;
  logic         rst;
  logic         i_cmd_valid;
  logic [5:0]   i_qbit_num;
  logic [15:0]  i_ins_num;
  logic         s_ctx_valid;
  logic         s_ctx_ready;
  logic [63:0]  s_ctx_data;
  logic         o_ctx_en;
  logic         o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic         o_state_ena;
  logic         o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic [5:0]   o_qbit_num;
  logic         o_qea_start;
  logic         i_qea_complete;
  logic         o_busy;
  logic         o_done;
  logic         o_err;
`ifdef QEA_HOST_LOADER_CYCLE_CNT_EN
  logic [31:0]  o_run_cycles;
`endif

  qea_host_loader dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_valid    (i_cmd_valid),
    .i_qbit_num     (i_qbit_num),
    .i_ins_num      (i_ins_num),
    .s_ctx_valid    (s_ctx_valid),
    .s_ctx_ready    (s_ctx_ready),
    .s_ctx_data     (s_ctx_data),
    .o_ctx_en       (o_ctx_en),
    .o_ctx_wea      (o_ctx_wea),
    .o_ctx_addr     (o_ctx_addr),
    .o_ctx_data     (o_ctx_data),
    .o_state_ena    (o_state_ena),
    .o_state_wea    (o_state_wea),
    .o_state_addra  (o_state_addra),
    .o_state_dina   (o_state_dina),
    .o_qbit_num     (o_qbit_num),
    .o_qea_start    (o_qea_start),
    .i_qea_complete (i_qea_complete),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
`ifdef QEA_HOST_LOADER_CYCLE_CNT_EN
    ,
    .o_run_cycles   (o_run_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int qbit;
    int ins;
    int valid_pct;
    int complete_dly;
    bit poke;
    bit exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } ctx_exp_t;

  typedef struct {
    logic [15:0]  addr;
    logic [255:0] data;
  } st_exp_t;

  ctx_exp_t exp_ctx[$];
  st_exp_t  exp_state[$];
  vec_t     vecs[6];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard: every RAM write must match the head of its expectation queue.
  always @(negedge clk) begin
    if (o_ctx_en) begin
      if (exp_ctx.size() == 0) begin
        fail_now($sformatf("ctx_unexpected_write addr=%0h", o_ctx_addr));
      end else begin
        ctx_exp_t e;
        e = exp_ctx.pop_front();
        check("ctx_addr", o_ctx_addr, e.addr);
        check("ctx_data", o_ctx_data, e.data);
        check("ctx_wea", o_ctx_wea, 1'b1);
      end
    end
    if (o_state_ena) begin
      if (exp_state.size() == 0) begin
        fail_now($sformatf("state_unexpected_write addr=%0h", o_state_addra));
      end else begin
        st_exp_t e;
        e = exp_state.pop_front();
        check("state_addr", o_state_addra, e.addr);
        check("state_data", o_state_dina, e.data);
        check("state_wea", o_state_wea, 1'b1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {s_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea,
                           o_qea_start, o_busy, o_done, o_err, o_qbit_num}, '0);
    check({tag, "_ctx"}, {o_ctx_addr, o_ctx_data}, '0);
    check({tag, "_state_addr"}, o_state_addra, '0);
    check({tag, "_state_data"}, o_state_dina, '0);
  endtask

  task automatic push_state(input int qbit);
    int words;
    words = 1 << (qbit - 2);
    for (int w = 0; w < words; w++)
      exp_state.push_back('{addr: 16'(w), data: (w == 0) ? BASIS : 256'h0});
  endtask

  // Entered and left on a negedge.
  task automatic run_vec(input vec_t v);
    int          sent;
    int          cyc;
    int          exp_run;
    bit          got_start;
    logic [63:0] d;

    i_cmd_valid = 1'b1;
    i_qbit_num  = 6'(v.qbit);
    i_ins_num   = 16'(v.ins);
    if (!v.exp_err) push_state(v.qbit);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("err_after_cmd", o_err, v.exp_err);
    check("busy_after_cmd", o_busy, !v.exp_err);
    if (v.exp_err) begin
      repeat (3) @(negedge clk);
      check("busy_illegal", o_busy, 1'b0);
      check("ready_illegal", s_ctx_ready, 1'b0);
      check("err_sticky", o_err, 1'b1);
      return;
    end
    check("qbit_latched", o_qbit_num, 6'(v.qbit));

    sent      = 0;
    cyc       = 0;
    got_start = 1'b0;
    while (!got_start && cyc < 4000) begin
      if (o_qea_start) begin
        got_start = 1'b1;
      end else begin
        if (sent < v.ins) begin
          s_ctx_valid = ($urandom_range(99) < v.valid_pct);
          d = {$urandom, $urandom};
          s_ctx_data = d;
          if (s_ctx_valid && s_ctx_ready) begin
            exp_ctx.push_back('{addr: 16'(sent), data: d});
            sent++;
          end
        end else begin
          check("ready_after_last", s_ctx_ready, 1'b0);
          s_ctx_valid = 1'b1;
          s_ctx_data  = '1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    s_ctx_valid = 1'b0;
    if (!got_start) begin
      fail_now("start_timeout");
      return;
    end
    check("beats_accepted", sent, v.ins);
    check("ctx_all_written", exp_ctx.size(), 0);
    check("state_all_written", exp_state.size(), 0);
    check("busy_at_start", o_busy, 1'b1);

    exp_run = (v.complete_dly == 0) ? 1 : v.complete_dly;
    if (v.complete_dly == 0) i_qea_complete = 1'b1;
    for (int c = 1; c <= exp_run; c++) begin
      @(negedge clk);
      if (c == 1) check("start_one_cycle", o_qea_start, 1'b0);
      if (v.poke && c == 1) begin
        i_cmd_valid = 1'b1;
        i_qbit_num  = 6'd9;
        i_ins_num   = 16'd5;
      end
      if (v.poke && c == 2) begin
        i_cmd_valid = 1'b0;
        check("qbit_after_poke", o_qbit_num, 6'(v.qbit));
      end
      if (c == exp_run) check("done_not_early", o_done, 1'b0);
      if (c == v.complete_dly) i_qea_complete = 1'b1;
    end
    @(negedge clk);
    i_qea_complete = 1'b0;
    check("done_pulse", o_done, 1'b1);
    check("busy_in_done", o_busy, 1'b1);
`ifdef QEA_HOST_LOADER_CYCLE_CNT_EN
    check("run_cycles", o_run_cycles, 32'(exp_run));
`endif
    @(negedge clk);
    check("done_one_cycle", o_done, 1'b0);
    check("busy_after_done", o_busy, 1'b0);
    check("start_no_rerun", o_qea_start, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    vecs[0] = '{qbit: 5,  ins: 171, valid_pct: 100, complete_dly: 500, poke: 1'b0, exp_err: 1'b0};
    vecs[1] = '{qbit: 1,  ins: 3,   valid_pct: 100, complete_dly: 0,   poke: 1'b0, exp_err: 1'b1};
    vecs[2] = '{qbit: 7,  ins: 40,  valid_pct: 50,  complete_dly: 20,  poke: 1'b1, exp_err: 1'b0};
    vecs[3] = '{qbit: 2,  ins: 0,   valid_pct: 100, complete_dly: 0,   poke: 1'b0, exp_err: 1'b0};
    vecs[4] = '{qbit: 19, ins: 2,   valid_pct: 100, complete_dly: 0,   poke: 1'b0, exp_err: 1'b1};
    vecs[5] = '{qbit: 4,  ins: 9,   valid_pct: 30,  complete_dly: 3,   poke: 1'b0, exp_err: 1'b0};

    rst            = 1'b1;
    i_cmd_valid    = 1'b0;
    i_qbit_num     = '0;
    i_ins_num      = '0;
    s_ctx_valid    = 1'b0;
    s_ctx_data     = '0;
    i_qea_complete = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while the basis-state writer is at word 3.
    i_cmd_valid = 1'b1;
    i_qbit_num  = 6'd5;
    i_ins_num   = 16'd0;
    push_state(5);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    cyc = 0;
    while (!(o_state_ena && o_state_addra == 16'd3) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) fail_now("word3_timeout");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    exp_state.delete();
    @(negedge clk);
    check("idle_after_reset", o_busy, 1'b0);
    check("no_write_after_reset", o_state_ena, 1'b0);

    run_vec(vecs[3]);

    check("ctx_queue_drained", exp_ctx.size(), 0);
    check("state_queue_drained", exp_state.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
